// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master issues operands with start; the slave returns diff/borrow with a done pulse.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// A registered borrow links successive full-subtractor slices; a three-state FSM sequences the operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic a_bit, b_bit, d_bit, bout;
    logic accept;

    // Full-subtractor slice on the current LSBs and the registered borrow.
    assign a_bit  = a_sh_q[0];
    assign b_bit  = b_sh_q[0];
    assign d_bit  = a_bit ^ b_bit ^ bin_q;
    assign bout   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
    assign accept = (state_q != ST_RUN) && bus.start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values, so ordering here is irrelevant.
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its hold value first, so no path can infer a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                bin_d  = bout;
                if (cnt_q == LAST) begin
                    // Result registers change only here, so partial sums never reach the outputs.
                    state_d  = ST_DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bout;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = bus.start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            a_sh_d = bus.a;
            b_sh_d = bus.b;
            res_d  = '0;
            bin_d  = 1'b0;
            cnt_d  = '0;
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule
